hazard_flush_sequencer: RTL and testbench

- Central pipeline control for the 5-stage MIPS core.
- Detects load-use and ID-stage branch-operand hazards, and sequences PC/IF-ID stalls and bubbles.
- Issues IF/ID flushes for jump, taken bne and jr.
- Freezes the whole pipeline while data memory is busy, with a watchdog timeout.
- Sits between the decode/forwarding logic and the pipeline register enables.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_detect.sv | 32 +++
 rtl/hazard_flush_sequencer.sv | 137 +++++++++++++
 tb/tb_hazard_flush_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/flush sequencer.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int REG_W_DEFAULT = 5;
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and ID-stage branch-operand hazard detection.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_dst,
    output logic             stall
);

    logic lu, br1, br2;

    // $zero is hard-wired, so a write to it can never create a dependency.
    function automatic logic hit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
        return (dst == src) && (dst != REG_W'(ZERO_REG));
    endfunction

    assign lu  = ex_memread && (hit(ex_dst, id_rs) || (id_uses_rt && hit(ex_dst, id_rt)));
    assign br1 = id_branch && ex_regwrite && (hit(ex_dst, id_rs) || hit(ex_dst, id_rt));
    assign br2 = id_branch && mem_memread && (hit(mem_dst, id_rs) || hit(mem_dst, id_rt));

    assign stall = lu | br1 | br2;

endmodule

// File: rtl/hazard_flush_sequencer.sv
// Pipeline stall/flush/freeze control with data-memory watchdog.
// Optional macro HAZARD_PERF_EN adds the stall_cnt performance counter output.
module hazard_flush_sequencer
    import hazard_pkg::*;
#(
    parameter int REG_W   = REG_W_DEFAULT,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             jump,
    input  logic             bne_taken,
    input  logic             jr,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             if_flush,
    output logic             id_flush,
    output logic             pipe_freeze,
    output logic             err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    state_t          state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            stall, miss, frozen;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_branch   (id_branch),
        .ex_memread  (ex_memread),
        .ex_regwrite (ex_regwrite),
        .ex_dst      (ex_dst),
        .mem_memread (mem_memread),
        .mem_dst     (mem_dst),
        .stall       (stall)
    );

    // A miss freezes the pipe in the same cycle it is seen, before MEM_WAIT is entered.
    assign miss   = dmem_req && !dmem_ready;
    assign frozen = (state_q == MEM_WAIT) || miss;

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                wd_d = '0;
                if (miss) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                    wd_d    = '0;
                end else begin
                    if (wd_q != TO_W'(TIMEOUT)) wd_d = wd_q + TO_W'(1);
                    if (wd_d == TO_W'(TIMEOUT)) err_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // Freeze beats stall beats redirect; redirects are simply re-presented later.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        pipe_freeze = 1'b0;
        if (frozen) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
        end else if (stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            id_flush   = 1'b1;
        end else begin
            if_flush = jump | bne_taken | jr;
            id_flush = bne_taken | jr;
        end
    end

    assign err = err_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!pc_write && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_flush_sequencer.sv
// Directed bench for hazard_flush_sequencer (watchdog TIMEOUT shortened to 4).
module tb_hazard_flush_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
    logic       id_uses_rt, id_branch, jump, bne_taken, jr;
    logic       ex_memread, ex_regwrite, mem_memread, dmem_req, dmem_ready;
    logic       pc_write, ifid_write, if_flush, id_flush, pipe_freeze, err;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_flush_sequencer #(.REG_W(5), .TIMEOUT(4), .TO_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_branch   (id_branch),
        .jump        (jump),
        .bne_taken   (bne_taken),
        .jr          (jr),
        .ex_memread  (ex_memread),
        .ex_regwrite (ex_regwrite),
        .ex_dst      (ex_dst),
        .mem_memread (mem_memread),
        .mem_dst     (mem_dst),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .if_flush    (if_flush),
        .id_flush    (id_flush),
        .pipe_freeze (pipe_freeze),
        .err         (err)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // Expected vector order: {pc_write, ifid_write, if_flush, id_flush, pipe_freeze, err}
    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        #1;
        obs = {pc_write, ifid_write, if_flush, id_flush, pipe_freeze, err};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_dst = 5'd0; mem_dst = 5'd0;
        id_uses_rt = 1'b0; id_branch = 1'b0; jump = 1'b0; bne_taken = 1'b0; jr = 1'b0;
        ex_memread = 1'b0; ex_regwrite = 1'b0; mem_memread = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        chk("reset_state", 6'b110000);
        tick();
        reset = 1'b0;
        chk("post_reset_idle", 6'b110000);

        // Load-use on rs, then clears
        tick(); ex_memread = 1'b1; ex_dst = 5'd8; id_rs = 5'd8;
        chk("lu_rs", 6'b000100);
        tick(); ex_memread = 1'b0;
        chk("lu_rs_clear", 6'b110000);

        // Load-use on rt only counts when rt is read
        tick(); idle(); ex_memread = 1'b1; ex_dst = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
        chk("lu_rt", 6'b000100);
        tick(); id_uses_rt = 1'b0;
        chk("lu_rt_unused", 6'b110000);

        // Register zero never matches
        tick(); idle(); ex_memread = 1'b1; ex_dst = 5'd0; id_rs = 5'd0;
        chk("zero_reg", 6'b110000);

        // Branch behind a load: br1 then br2, bne_taken ignored while stalled
        tick(); idle(); id_branch = 1'b1; id_rs = 5'd9; bne_taken = 1'b1;
        ex_regwrite = 1'b1; ex_memread = 1'b1; ex_dst = 5'd9;
        chk("br1_stall", 6'b000100);
        tick(); ex_regwrite = 1'b0; ex_memread = 1'b0; ex_dst = 5'd0; mem_memread = 1'b1; mem_dst = 5'd9;
        chk("br2_stall", 6'b000100);
        tick(); mem_memread = 1'b0; mem_dst = 5'd0;
        chk("bne_redirect", 6'b111100);

        // br1 via rt; non-branch ALU producer is forwarded, no stall
        tick(); idle(); id_branch = 1'b1; id_rs = 5'd2; id_rt = 5'd9; ex_regwrite = 1'b1; ex_dst = 5'd9;
        chk("br1_rt", 6'b000100);
        tick(); id_branch = 1'b0;
        chk("alu_no_branch", 6'b110000);

        // Jumps
        tick(); idle(); jump = 1'b1;
        chk("jump_alone", 6'b111000);
        tick(); ex_memread = 1'b1; ex_dst = 5'd8; id_rs = 5'd8;
        chk("jump_vs_lu", 6'b000100);
        tick(); idle(); jr = 1'b1;
        chk("jr_alone", 6'b111100);

        // RUN access that completes immediately is not a freeze
        tick(); idle(); dmem_req = 1'b1; dmem_ready = 1'b1;
        chk("dmem_hit", 6'b110000);

        // Memory wait with jr pending; err sets after 4 waiting cycles
        tick(); idle(); jr = 1'b1; dmem_req = 1'b1;
        chk("mw_run_miss", 6'b000010);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk($sformatf("mw_wait_%0d", i), 6'b000010);
        end
        tick(); dmem_ready = 1'b1;
        chk("mw_ready", 6'b000011);
        tick(); dmem_req = 1'b0; dmem_ready = 1'b0;
        chk("mw_jr_after", 6'b111101);
        tick(); idle();
        chk("err_sticky", 6'b110001);

        reset = 1'b1;
        chk("reset_clears_err", 6'b110000);
        tick(); reset = 1'b0;

        // Timeout: never ready, err after 4 MEM_WAIT cycles, then reset mid-wait
        tick(); dmem_req = 1'b1;
        chk("to_run_miss", 6'b000010);
        for (int i = 2; i <= 11; i++) begin
            tick();
            chk($sformatf("to_wait_%0d", i), {5'b00001, (i >= 6) ? 1'b1 : 1'b0});
        end
        idle();
        reset = 1'b1;
        chk("reset_mid_wait", 6'b110000);
        tick(); reset = 1'b0;
        chk("after_reset", 6'b110000);

        // Ready followed by a new miss: counter restarts from zero
        tick(); dmem_req = 1'b1;
        chk("fresh_first", 6'b000010);
        tick(); chk("fresh_mw1", 6'b000010);
        tick(); chk("fresh_mw2", 6'b000010);
        tick(); dmem_ready = 1'b1;
        chk("fresh_ready", 6'b000010);
        tick(); dmem_ready = 1'b0;
        chk("fresh_reentry", 6'b000010);
        for (int j = 0; j <= 4; j++) begin
            tick();
            chk($sformatf("fresh_wait_%0d", j), {5'b00001, (j == 4) ? 1'b1 : 1'b0});
        end

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
